ripple_sample_pwm: RTL and testbench
====================================

RIPPLE_SAMPLE_PWM -- requirements
Module: ripple_sample_pwm

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth per input bit (legal 2..3).
REQ-002 SHALL have parameter STABLE_CYCLES, default 2, meaning consecutive equal synchronized samples required before a value is accepted (legal 1..7).
REQ-003 SHALL have port clk  input  1  single clock; all state clocked on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 SHALL have port ena  input  1  enable; when low, all state holds.
REQ-006 SHALL have port cnt_in  input  8  asynchronous count from upstream 8-bit ripple counter; bits may settle at different times.
REQ-007 SHALL have port cnt_q  output  8  last accepted (filtered) count.
REQ-008 SHALL have port cnt_valid  output  1  one-cycle pulse when cnt_q takes a new value.
REQ-009 SHALL have port pwm_out  output  1  PWM whose duty equals duty_q/256.
REQ-010 SHALL have port pwm_wrap  output  1  one-cycle pulse on the cycle the PWM counter is 8'hFF.

Function
REQ-011 Each cnt_in bit SHALL pass through SYNC_STAGES flops; sync latency is SYNC_STAGES cycles.
REQ-012 A stability counter SHALL increment while the synchronized word equals the previous cycle's synchronized word, and clear to 0 when it differs.
REQ-013 When the stability counter reaches STABLE_CYCLES-1 and the synchronized word differs from cnt_q, cnt_q SHALL load that word and cnt_valid SHALL pulse for exactly one cycle.
REQ-014 The stability counter SHALL saturate at STABLE_CYCLES-1; a held stable word SHALL NOT produce repeated cnt_valid pulses.
REQ-015 The accept latency from a stable cnt_in change to cnt_valid SHALL be SYNC_STAGES+STABLE_CYCLES cycles (4 at defaults).
REQ-016 An 8-bit free-running PWM counter SHALL increment every enabled cycle, wrapping 8'hFF->8'h00.
REQ-017 duty_q SHALL load cnt_q only on the cycle pwm_wrap is high; a cnt_q change mid-period SHALL NOT alter the current period.
REQ-018 pwm_out SHALL be registered: high in the cycle after the PWM counter value is < duty_q; duty 0 gives constant low, duty 255 gives 255 high cycles out of 256.
REQ-019 When cnt_valid and pwm_wrap coincide, duty_q SHALL load the old cnt_q (new value takes effect next period).
REQ-020 With ena low, the synchronizer, stability counter, cnt_q, PWM counter and pwm_out SHALL hold; cnt_valid and pwm_wrap SHALL be 0.

Reset
REQ-021 rst_n low SHALL asynchronously clear synchronizer flops, stability counter, cnt_q, duty_q, PWM counter, cnt_valid, pwm_out, pwm_wrap to 0.
REQ-022 Reset asserted mid-period SHALL abort the period; after release, the first enabled cycle SHALL start PWM count at 0 and cnt_in SHALL be re-accepted under REQ-013.

Configuration
REQ-023 With macro RIPPLE_SAMPLE_DELTA_EN defined, SHALL add outputs delta (8 bits, cnt_q_new minus cnt_q_old mod 256) and delta_valid (aligned with cnt_valid); both reset to 0.
REQ-024 Without RIPPLE_SAMPLE_DELTA_EN, the delta and delta_valid ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-025 A shared package ripple_pkg SHALL hold CNT_W=8, PWM_W=8, and the default SYNC_STAGES/STABLE_CYCLES constants.
REQ-026 The PWM counter/compare/duty register SHALL be a sub-module pwm_gen8; synchronizer and filter stay in the top.

Verification
REQ-027 Reset, hold cnt_in=8'h00, pulse ena high -> cnt_q=0, no cnt_valid, pwm_out constant 0.
REQ-028 Step cnt_in 8'h00->8'h2A, held stable -> cnt_valid exactly once, 4 cycles later, cnt_q=8'h2A; no further pulses over 100 cycles.
REQ-029 Toggle cnt_in 8'h7F<->8'h80 every cycle (ripple glitch) then settle at 8'h80 -> no cnt_q update during toggling, single accept of 8'h80.
REQ-030 cnt_q=8'h40 accepted mid-period -> current period unchanged; next period pwm_out high for 64 of 256 cycles; duty 8'hFF -> 255 of 256.
REQ-031 Assert rst_n low mid-period with duty 8'h80 -> all outputs 0 immediately (before next clk edge); recovery per REQ-022.
REQ-032 RIPPLE_SAMPLE_DELTA_EN defined, accept 8'hFE then 8'h03 -> delta=8'h05 with delta_valid coincident with cnt_valid.

Source files
------------

// File: rtl/ripple_pkg.sv
// ============================================================================
// ripple_pkg: shared widths and default parameters for ripple_sample_pwm.
// Rev 1.0
// ============================================================================
`default_nettype none

package ripple_pkg;
  localparam int CNT_W             = 8;
  localparam int PWM_W             = 8;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 2;
  // Wide enough for the largest stability threshold (STABLE_CYCLES-1 = 6)
  localparam int STAB_W            = 3;
endpackage

`default_nettype wire

// File: rtl/pwm_gen8.sv
// ============================================================================
// pwm_gen8: free-running 8-bit PWM with duty register reloaded at period wrap.
// Rev 1.0
// ============================================================================
`default_nettype none

module pwm_gen8
  import ripple_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [PWM_W-1:0] duty_src,
  output logic             pwm_out,
  output logic             pwm_wrap
);

  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] duty_q;
  logic             at_top;

  assign at_top   = (pwm_cnt == '1);
  assign pwm_wrap = ena & at_top;

  // Duty only changes at the wrap edge so a period is never altered mid-flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
      pwm_out <= 1'b0;
    end else if (ena) begin
      pwm_cnt <= pwm_cnt + 1'b1;
      pwm_out <= (pwm_cnt < duty_q);
      if (at_top) begin
        duty_q <= duty_src;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ripple_sample_pwm.sv
// ============================================================================
// ripple_sample_pwm: synchronize and stability-filter a ripple count, drive PWM.
// Optional delta outputs with macro RIPPLE_SAMPLE_DELTA_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module ripple_sample_pwm
  import ripple_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [CNT_W-1:0] cnt_in,
  output logic [CNT_W-1:0] cnt_q,
  output logic             cnt_valid,
  output logic             pwm_out,
  output logic             pwm_wrap
`ifdef RIPPLE_SAMPLE_DELTA_EN
  ,
  output logic [CNT_W-1:0] delta,
  output logic             delta_valid
`endif
);

  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][CNT_W-1:0] sync_ff;
  logic [CNT_W-1:0]                  sync_word;
  logic [CNT_W-1:0]                  prev_word;
  logic [CNT_W-1:0]                  prev_q;
  logic [STAB_W-1:0]                 stab;
  logic [STAB_W-1:0]                 stab_next;
  logic                              accept;
  logic                              valid_r;
  logic [PWM_W-1:0]                  duty_src;

  assign sync_word = sync_ff[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else if (ena) begin
      sync_ff[0] <= cnt_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_ff[i] <= sync_ff[i-1];
      end
    end
  end

  // Accept is judged on the next stability value so latency is SYNC+STABLE
  always_comb begin
    stab_next = '0;
    if (sync_word == prev_word) begin
      stab_next = (stab == STAB_MAX) ? stab : stab + 1'b1;
    end
    accept = (stab_next == STAB_MAX) && (sync_word != cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_word <= '0;
      stab      <= '0;
      cnt_q     <= '0;
      prev_q    <= '0;
      valid_r   <= 1'b0;
    end else if (ena) begin
      prev_word <= sync_word;
      stab      <= stab_next;
      valid_r   <= accept;
      if (accept) begin
        cnt_q  <= sync_word;
        prev_q <= cnt_q;
      end
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign cnt_valid = valid_r & ena;

  // A wrap coinciding with a fresh accept still loads the pre-accept count
  assign duty_src = valid_r ? prev_q : cnt_q;

  pwm_gen8 u_pwm (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .duty_src (duty_src),
    .pwm_out  (pwm_out),
    .pwm_wrap (pwm_wrap)
  );

`ifdef RIPPLE_SAMPLE_DELTA_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delta <= '0;
    end else if (ena && accept) begin
      delta <= sync_word - cnt_q;
    end
  end

  assign delta_valid = cnt_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ripple_sample_pwm.sv
// ============================================================================
// tb_ripple_sample_pwm: directed + random checks against a window/period model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ripple_sample_pwm;

  localparam int SYNC = 2;
  localparam int STAB = 2;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       ena    = 1'b0;
  logic [7:0] cnt_in = 8'h00;
  logic [7:0] cnt_q;
  logic       cnt_valid;
  logic       pwm_out;
  logic       pwm_wrap;
`ifdef RIPPLE_SAMPLE_DELTA_EN
  logic [7:0] delta;
  logic       delta_valid;
`endif

  always #5 clk = ~clk;

  ripple_sample_pwm #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .cnt_in    (cnt_in),
    .cnt_q     (cnt_q),
    .cnt_valid (cnt_valid),
    .pwm_out   (pwm_out),
`ifdef RIPPLE_SAMPLE_DELTA_EN
    .delta       (delta),
    .delta_valid (delta_valid),
`endif
    .pwm_wrap  (pwm_wrap)
  );

  int total = 0;
  int bad   = 0;

  // Reference: input delay line, window of recent synced words, period position
  logic [7:0] m_pipe[$];
  logic [7:0] m_hist[$];
  logic [7:0] m_q, m_qold, m_delta, m_duty;
  bit         m_valid, m_pwm;
  int         m_p;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pipe = {};
    repeat (SYNC) m_pipe.push_back(8'h00);
    m_hist  = {8'h00};
    m_q     = 8'h00;
    m_qold  = 8'h00;
    m_delta = 8'h00;
    m_duty  = 8'h00;
    m_valid = 1'b0;
    m_pwm   = 1'b0;
    m_p     = 0;
  endtask

  task automatic model_edge();
    logic [7:0] w;
    bit         stable;
    bit         new_pwm;
    if (!ena) begin
      m_valid = 1'b0;
      return;
    end
    w = m_pipe.pop_front();
    m_pipe.push_back(cnt_in);
    m_hist.push_back(w);
    if (m_hist.size() > STAB) void'(m_hist.pop_front());
    stable = (m_hist.size() == STAB);
    foreach (m_hist[i]) if (m_hist[i] != w) stable = 1'b0;
    new_pwm = (m_p < int'(m_duty));
    if (m_p == 255) m_duty = m_valid ? m_qold : m_q;
    m_p   = (m_p + 1) % 256;
    m_pwm = new_pwm;
    if (stable && w != m_q) begin
      m_delta = w - m_q;
      m_qold  = m_q;
      m_q     = w;
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("cnt_q", 32'(cnt_q), 32'(m_q));
    check("cnt_valid", 32'(cnt_valid), 32'(m_valid && ena));
    check("pwm_out", 32'(pwm_out), 32'(m_pwm));
    check("pwm_wrap", 32'(pwm_wrap), 32'(ena && m_p == 255));
`ifdef RIPPLE_SAMPLE_DELTA_EN
    check("delta_valid", 32'(delta_valid), 32'(m_valid && ena));
    if (m_valid && ena) check("delta", 32'(delta), 32'(m_delta));
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cnt_q"}, 32'(cnt_q), 32'h0);
    check({tag, "_cnt_valid"}, 32'(cnt_valid), 32'h0);
    check({tag, "_pwm_out"}, 32'(pwm_out), 32'h0);
    check({tag, "_pwm_wrap"}, 32'(pwm_wrap), 32'h0);
`ifdef RIPPLE_SAMPLE_DELTA_EN
    check({tag, "_delta"}, 32'(delta), 32'h0);
    check({tag, "_delta_valid"}, 32'(delta_valid), 32'h0);
`endif
  endtask

  task automatic wait_valid(input int max, output int n);
    bit found = 1'b0;
    n = 0;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (cnt_valid === 1'b1) begin
        n     = i;
        found = 1'b1;
        break;
      end
    end
    check("valid_timeout", 32'(found), 32'h1);
  endtask

  task automatic wait_wrap();
    bit found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (pwm_wrap === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("wrap_timeout", 32'(found), 32'h1);
  endtask

  task automatic count_high(input string tag, input int exp);
    int h = 0;
    repeat (256) begin
      tick();
      h += int'(pwm_out);
    end
    check(tag, 32'(h), 32'(exp));
  endtask

  initial begin
    int n;
    int pulses;
    int h;
    model_reset();
    #1;
    check_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Idle count with a short ena pulse: nothing accepted, PWM stays low
    ena = 1'b1;
    h = 0;
    repeat (3) begin tick(); h += int'(pwm_out) + int'(cnt_valid); end
    ena = 1'b0;
    repeat (3) begin tick(); h += int'(pwm_out) + int'(cnt_valid); end
    ena = 1'b1;
    repeat (5) begin tick(); h += int'(pwm_out) + int'(cnt_valid); end
    check("idle_activity", 32'(h), 32'h0);

    // Clean step: single accept after 4 cycles, no repeats
    cnt_in = 8'h2A;
    wait_valid(20, n);
    check("accept_latency", 32'(n), 32'd4);
    check("q_2a", 32'(cnt_q), 32'h2A);
    pulses = 0;
    repeat (100) begin tick(); pulses += int'(cnt_valid); end
    check("no_repeat_pulse", 32'(pulses), 32'h0);

    // Ripple glitch between 7F and 80, then settle
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cnt_in = (i % 2 == 0) ? 8'h7F : 8'h80;
      tick();
      pulses += int'(cnt_valid);
    end
    check("toggle_no_accept", 32'(pulses), 32'h0);
    cnt_in = 8'h80;
    pulses = 0;
    repeat (12) begin tick(); pulses += int'(cnt_valid); end
    check("settle_single_accept", 32'(pulses), 32'h1);
    check("q_80", 32'(cnt_q), 32'h80);

    // Mid-period duty change, then full duty
    wait_wrap();
    repeat (40) tick();
    cnt_in = 8'h40;
    wait_valid(20, n);
    wait_wrap();
    count_high("duty_40_high", 64);
    cnt_in = 8'hFF;
    wait_valid(20, n);
    wait_wrap();
    count_high("duty_ff_high", 255);

    // Asynchronous reset in the middle of a duty-80 period
    cnt_in = 8'h80;
    wait_valid(20, n);
    wait_wrap();
    count_high("duty_80_high", 128);
    repeat (50) tick();
    #2 rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    wait_valid(20, n);
    check("reaccept_latency", 32'(n), 32'd4);
    check("reaccept_q", 32'(cnt_q), 32'h80);

    // Accept landing on the wrap cycle: old count sets the next period
    wait_wrap();
    repeat (252) tick();
    cnt_in = 8'h10;
    repeat (4) tick();
    check("coincide_valid", 32'(cnt_valid), 32'h1);
    check("coincide_wrap", 32'(pwm_wrap), 32'h1);
    count_high("coincide_old_duty", 128);
    count_high("coincide_new_duty", 16);

`ifdef RIPPLE_SAMPLE_DELTA_EN
    cnt_in = 8'hFE;
    wait_valid(20, n);
    cnt_in = 8'h03;
    wait_valid(20, n);
    check("delta_fe_03", 32'(delta), 32'h05);
    check("delta_valid_aligned", 32'(delta_valid), 32'(cnt_valid));
`endif

    // Random held values, single-cycle glitches and ena gaps
    for (int k = 0; k < 120; k++) begin
      cnt_in = 8'($urandom);
      ena    = ($urandom_range(0, 9) != 0);
      repeat ($urandom_range(1, 7)) tick();
    end
    ena = 1'b1;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
